mem_stage_lsu: RTL

Load/store unit for the MEM stage of the 5-stage pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register. Converts memRead/memWrite ops into a req/ack data-memory transaction and generates byte strobes and write data. Returns sign- or zero-extended load data as readDataM, and stalls the pipeline until the access completes.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/mem_stage_lsu_load_extend.sv | 27 ++
 rtl/mem_stage_lsu.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Optional bus timeout: define MEM_TIMEOUT_EN.
package mem_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Misaligned halfword/word or a funct3 with no matching access.
  function automatic logic acc_fault(
    input logic [2:0] f3,
    input logic [1:0] off,
    input logic       we
  );
    logic bad_f3;
    logic mis;
    if (we)
      bad_f3 = f3[2] | (f3[1:0] == 2'b11);
    else
      bad_f3 = (f3[1:0] == 2'b11) | (f3 == 3'b110);
    mis = ((f3[1:0] == F3_H[1:0]) & off[0])
        | ((f3[1:0] == F3_W[1:0]) & (off != 2'b00));
    return bad_f3 | mis;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_extend.sv
// Load lane select and sign/zero extension.
// Pure combinational; shared with the WB-path debug checker.
module load_extend
  import mem_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      f3_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] sh;

  assign sh = rdata_i >> {off_i, 3'b000};

  always_comb begin
    data_o = sh;
    unique case (f3_i)
      F3_B:    data_o = {{24{sh[7]}}, sh[7:0]};
      F3_H:    data_o = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   data_o = {24'b0, sh[7:0]};
      F3_HU:   data_o = {16'b0, sh[15:0]};
      default: data_o = sh;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data bus, byte lanes, stall.
// Define MEM_TIMEOUT_EN to add an ack timeout raising busErrM.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
)
(
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            memReadM,
  input  logic            memWriteM,
  input  logic            flushM,
  input  logic [2:0]      funct3M,
  input  logic [XLEN-1:0] aluResultM,
  input  logic [XLEN-1:0] writeDataM,
  output logic [XLEN-1:0] readDataM,
  output logic            stallM,
  output logic            faultM,
  output logic            busErrM,
  output logic            memReq,
  output logic            memWe,
  output logic [XLEN-1:0] memAddr,
  output logic [XLEN-1:0] memWdata,
  output logic [3:0]      memWstrb,
  input  logic [XLEN-1:0] memRdata,
  input  logic            memAck
);

  lsu_state_e      state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rd_q, rd_d;
  logic [3:0]      strb_q, strb_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;

  logic            op;
  logic            flt;
  logic [3:0]      strb_n;
  logic [XLEN-1:0] wdata_n;
  logic [XLEN-1:0] ext;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CLAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          berr_q, berr_d;
`endif

  assign op  = (memReadM | memWriteM) & ~flushM;
  assign flt = acc_fault(funct3M, aluResultM[1:0], memWriteM);

  always_comb begin
    strb_n  = '0;
    wdata_n = '0;
    if (memWriteM) begin
      unique case (1'b1)
        funct3M[1:0] == F3_B[1:0]: begin
          strb_n  = 4'b0001 << aluResultM[1:0];
          wdata_n = {4{writeDataM[7:0]}};
        end
        funct3M[1:0] == F3_H[1:0]: begin
          strb_n  = 4'b0011 << aluResultM[1:0];
          wdata_n = {2{writeDataM[15:0]}};
        end
        default: begin
          strb_n  = 4'b1111;
          wdata_n = writeDataM;
        end
      endcase
    end
  end

  load_extend u_ext (
    .rdata_i (memRdata),
    .off_i   (off_q),
    .f3_i    (f3_q),
    .data_o  (ext)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rd_d    = rd_q;
    fault_d = 1'b0;
    stallM  = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    berr_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (op && flt) begin
          fault_d = 1'b1;
          rd_d    = '0;
        end else if (op) begin
          stallM  = 1'b1;
          req_d   = 1'b1;
          we_d    = memWriteM;
          addr_d  = {aluResultM[XLEN-1:2], 2'b00};
          wdata_d = wdata_n;
          strb_d  = strb_n;
          f3_d    = funct3M;
          off_d   = aluResultM[1:0];
          state_d = REQ;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      REQ: begin
        stallM = 1'b1;
        if (memAck) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q)
            rd_d = ext;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CLAST) begin
          req_d   = 1'b0;
          rd_d    = '0;
          berr_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      strb_q  <= '0;
      f3_q    <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      fault_q <= fault_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      strb_q  <= strb_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= '0;
      berr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      berr_q <= berr_d;
    end
  end
  assign busErrM = berr_q;
`else
  assign busErrM = 1'b0;
`endif

  assign memReq    = req_q;
  assign memWe     = we_q;
  assign memAddr   = addr_q;
  assign memWdata  = wdata_q;
  assign memWstrb  = strb_q;
  assign readDataM = rd_q;
  assign faultM    = fault_q;

endmodule
